// File: rtl/cl_pkg.sv
// Shared constants, header field layout and FSM encoding for the Camera Link line packer.
package cl_pkg;

  function automatic int unsigned log2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++)
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    return result;
  endfunction

  localparam int unsigned DEF_FRAME_NUM_SIZE = 20;
  localparam int unsigned DEF_LINE_NUM_SIZE  = 12;
  localparam int unsigned DEF_DROP_CNT_SIZE  = 8;
  localparam logic [15:0] DEF_HDR_MARKER     = 16'hC1F0;

  localparam int unsigned CL_DATA_W  = 80;
  localparam int unsigned MSG_W      = 128;
  localparam int unsigned ACC_W      = 208;
  localparam int unsigned UNIT_W     = 16;
  localparam int unsigned BEAT_UNITS = CL_DATA_W / UNIT_W;
  localparam int unsigned MSG_UNITS  = MSG_W / UNIT_W;
  localparam int unsigned ACC_UNITS  = ACC_W / UNIT_W;
  localparam int unsigned FILL_W     = log2(ACC_UNITS);

  localparam int unsigned HDR_MARKER_LSB = 112;
  localparam int unsigned HDR_MARKER_W   = 16;
  localparam int unsigned HDR_NUM_LSB    = 80;
  localparam int unsigned HDR_NUM_W      = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_FRAME,
    ST_ACTIVE,
    ST_DROP
  } cl_state_e;

endpackage

// File: rtl/cl_gearbox_80to128.sv
// 80-to-128 bit gearbox: beats pack LSB-first into a 208-bit accumulator tracked in
// 16-bit units; a full 128-bit word is popped on the same cycle it completes.
module cl_gearbox_80to128
  import cl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 wr,
  input  logic                 flush,
  input  logic [CL_DATA_W-1:0] din,
  output logic [MSG_W-1:0]     word,
  output logic                 word_vld
);

  logic [ACC_W-1:0]  acc_q, acc_d, base_acc, sum_acc;
  logic [FILL_W-1:0] fill_q, fill_d, base_fill, sum_fill;

  always_comb begin
    // clr drops the residual before this cycle's beat, so a new line can start at once
    base_acc  = clr ? '0 : acc_q;
    base_fill = clr ? '0 : fill_q;
    sum_acc   = base_acc | (ACC_W'(din) << (base_fill * UNIT_W));
    sum_fill  = base_fill + FILL_W'(BEAT_UNITS);
    acc_d     = base_acc;
    fill_d    = base_fill;
    word      = '0;
    word_vld  = 1'b0;
    if (flush) begin
      word     = base_acc[MSG_W-1:0];
      word_vld = (base_fill != '0);
      acc_d    = '0;
      fill_d   = '0;
    end else if (wr) begin
      if (sum_fill >= FILL_W'(MSG_UNITS)) begin
        word     = sum_acc[MSG_W-1:0];
        word_vld = 1'b1;
        acc_d    = sum_acc >> MSG_W;
        fill_d   = sum_fill - FILL_W'(MSG_UNITS);
      end else begin
        acc_d  = sum_acc;
        fill_d = sum_fill;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      fill_q <= '0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/cl_line_packer.sv
// Camera Link line packer: qualifies 80-bit pixel beats, prepends a per-line header and
// gearboxes the line into 128-bit message words, dropping the frame on FIFO overflow.
module cl_line_packer
  import cl_pkg::*;
#(
  parameter int unsigned FRAME_NUM_SIZE = DEF_FRAME_NUM_SIZE,
  parameter int unsigned LINE_NUM_SIZE  = DEF_LINE_NUM_SIZE,
  parameter logic [15:0] HDR_MARKER     = DEF_HDR_MARKER,
  parameter int unsigned DROP_CNT_SIZE  = DEF_DROP_CNT_SIZE
) (
  input  logic                      cl_clk,
  input  logic                      reset,
  input  logic                      capture_en,
  input  logic                      cl_fval,
  input  logic                      cl_lval,
  input  logic [CL_DATA_W-1:0]      cl_data,
  input  logic                      fpga_msg_overflow,
  output logic [MSG_W-1:0]          fpga_msg,
  output logic                      fpga_msg_valid,
  output logic [FRAME_NUM_SIZE-1:0] frame_num,
  output logic [LINE_NUM_SIZE-1:0]  line_num,
  output logic [DROP_CNT_SIZE-1:0]  dropped_frames,
  output logic                      sync_err
);

  logic                 cap_q, fval_q, lval_q, ovf_q, fval_prev_q, lv_prev_q;
  logic [CL_DATA_W-1:0] data_q;

  cl_state_e                 state_q, state_d;
  logic [FRAME_NUM_SIZE-1:0] frame_num_q, frame_num_d;
  logic [LINE_NUM_SIZE-1:0]  line_num_q, line_num_d;
  logic [DROP_CNT_SIZE-1:0]  dropped_q, dropped_d;
  logic                      sync_err_q, sync_err_d;
  logic                      line_on_q, line_on_d;
  logic                      flush_pend_q, flush_pend_d;
  logic [MSG_W-1:0]          msg_q, msg_d;
  logic                      msg_vld_q, msg_vld_d;

  logic lv, fval_rise, fval_fall, line_rise, line_fall, in_active, ovf_hit;
  logic hdr_go, beat_wr, end_line, gb_clr, gb_flush, gb_vld;
  logic [MSG_W-1:0]     gb_word, hdr_word;
  logic [HDR_NUM_W-1:0] hdr_num;

  // Input register stage; edges are judged against the previous registered sample
  always_ff @(posedge cl_clk or posedge reset) begin
    if (reset) begin
      cap_q       <= 1'b0;
      fval_q      <= 1'b0;
      lval_q      <= 1'b0;
      ovf_q       <= 1'b0;
      fval_prev_q <= 1'b0;
      lv_prev_q   <= 1'b0;
    end else begin
      cap_q       <= capture_en;
      fval_q      <= cl_fval;
      lval_q      <= cl_lval;
      ovf_q       <= fpga_msg_overflow;
      fval_prev_q <= fval_q;
      lv_prev_q   <= fval_q & lval_q;
    end
  end

  always_ff @(posedge cl_clk) data_q <= cl_data;

  always_comb begin
    lv        = fval_q & lval_q;
    fval_rise = fval_q & ~fval_prev_q;
    fval_fall = ~fval_q & fval_prev_q;
    line_rise = lv & ~lv_prev_q;
    line_fall = ~lv & lv_prev_q;
    in_active = cap_q && (state_q == ST_ACTIVE);
    ovf_hit   = in_active & ovf_q;
    hdr_go    = in_active & ~ovf_q & line_rise;
    beat_wr   = in_active & ~ovf_q & lv & (line_on_q | hdr_go);
    end_line  = in_active & ~ovf_q & line_fall & line_on_q;
    gb_clr    = ~cap_q | ovf_hit | hdr_go;
    gb_flush  = cap_q & flush_pend_q & ~hdr_go & ~ovf_hit;
  end

  always_comb begin
    hdr_num = '0;
    hdr_num[LINE_NUM_SIZE-1:0] = line_num_q;
    hdr_num[LINE_NUM_SIZE +: FRAME_NUM_SIZE] = frame_num_q;
    hdr_word = '0;
    hdr_word[HDR_MARKER_LSB +: HDR_MARKER_W] = HDR_MARKER;
    hdr_word[HDR_NUM_LSB +: HDR_NUM_W] = hdr_num;
  end

  cl_gearbox_80to128 u_gearbox (
    .clk      (cl_clk),
    .rst      (reset),
    .clr      (gb_clr),
    .wr       (beat_wr),
    .flush    (gb_flush),
    .din      (data_q),
    .word     (gb_word),
    .word_vld (gb_vld)
  );

  always_comb begin
    state_d = state_q;
    if (!cap_q) state_d = ST_IDLE;
    else begin
      case (state_q)
        ST_IDLE:       state_d = ST_WAIT_FRAME;
        ST_WAIT_FRAME: if (fval_rise) state_d = ST_ACTIVE;
        ST_ACTIVE:     if (ovf_q) state_d = ST_DROP;
                       else if (fval_fall) state_d = ST_WAIT_FRAME;
        ST_DROP:       if (fval_fall) state_d = ST_WAIT_FRAME;
        default:       state_d = ST_IDLE;
      endcase
    end

    frame_num_d = frame_num_q;
    line_num_d  = line_num_q;
    if (cap_q && state_q == ST_WAIT_FRAME && fval_rise) begin
      frame_num_d = frame_num_q + 1'b1;
      line_num_d  = '0;
    end else if (end_line) begin
      line_num_d = line_num_q + 1'b1;
    end

    dropped_d = (ovf_hit && dropped_q != '1) ? dropped_q + 1'b1 : dropped_q;
    // a pending flush at a line start means LVAL was low for only one cycle
    sync_err_d = sync_err_q | (hdr_go & flush_pend_q);

    line_on_d = line_on_q;
    if (!cap_q || ovf_hit || line_fall) line_on_d = 1'b0;
    else if (hdr_go)                    line_on_d = 1'b1;
    flush_pend_d = end_line;

    msg_d     = hdr_go ? hdr_word : (gb_vld ? gb_word : '0);
    msg_vld_d = hdr_go | gb_vld;
  end

  // Output register stage
  always_ff @(posedge cl_clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      frame_num_q  <= '0;
      line_num_q   <= '0;
      dropped_q    <= '0;
      sync_err_q   <= 1'b0;
      line_on_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      msg_q        <= '0;
      msg_vld_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_num_q  <= frame_num_d;
      line_num_q   <= line_num_d;
      dropped_q    <= dropped_d;
      sync_err_q   <= sync_err_d;
      line_on_q    <= line_on_d;
      flush_pend_q <= flush_pend_d;
      msg_q        <= msg_d;
      msg_vld_q    <= msg_vld_d;
    end
  end

  assign fpga_msg       = msg_q;
  assign fpga_msg_valid = msg_vld_q;
  assign frame_num      = frame_num_q;
  assign line_num       = line_num_q;
  assign dropped_frames = dropped_q;
  assign sync_err       = sync_err_q;

endmodule

// File: tb/tb_cl_line_packer.sv
// Bench for cl_line_packer: expected word streams come from a bit-stream model of each line.
module tb_cl_line_packer;

  logic         cl_clk = 1'b0;
  logic         reset, capture_en, cl_fval, cl_lval, fpga_msg_overflow;
  logic [79:0]  cl_data;
  logic [127:0] fpga_msg;
  logic         fpga_msg_valid;
  logic [19:0]  frame_num;
  logic [11:0]  line_num;
  logic [7:0]   dropped_frames;
  logic         sync_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] got_q[$];
  logic [127:0] exp_q[$];
  logic [79:0]  line_beats[32];
  int mdl_frame, mdl_lnum;

  typedef struct {
    int nbeats;
    int exp_words;
  } vec_t;
  vec_t tbl[6];

  always #5 cl_clk = ~cl_clk;

  cl_line_packer dut (
    .cl_clk            (cl_clk),
    .reset             (reset),
    .capture_en        (capture_en),
    .cl_fval           (cl_fval),
    .cl_lval           (cl_lval),
    .cl_data           (cl_data),
    .fpga_msg_overflow (fpga_msg_overflow),
    .fpga_msg          (fpga_msg),
    .fpga_msg_valid    (fpga_msg_valid),
    .frame_num         (frame_num),
    .line_num          (line_num),
    .dropped_frames    (dropped_frames),
    .sync_err          (sync_err)
  );

  always @(negedge cl_clk) if (!reset && fpga_msg_valid) got_q.push_back(fpga_msg);

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic [79:0] rand80();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[79:0];
  endfunction

  function automatic logic [127:0] hdr(input int frame, input int line);
    return {16'hC1F0, 20'(frame), 12'(line), 80'h0};
  endfunction

  // Line = header + its beats laid end to end LSB-first, cut into 128-bit words, last zero-padded.
  // keep >= 0 limits the data words (truncated lines).
  task automatic mdl_line(input int frame, input int line, input int n, input int keep);
    logic [2559:0] stream;
    int nw;
    stream = '0;
    for (int k = 0; k < n; k++) stream[k*80 +: 80] = line_beats[k];
    exp_q.push_back(hdr(frame, line));
    nw = (n * 80 + 127) / 128;
    if (keep >= 0 && keep < nw) nw = keep;
    for (int j = 0; j < nw; j++) exp_q.push_back(stream[j*128 +: 128]);
  endtask

  task automatic compare_stream(input string name);
    check({name, " word count"}, 128'(got_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check($sformatf("%s word%0d", name, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic drive_line(input int n, input int ovf_beat, input bit pattern, input bit cut);
    for (int k = 0; k < n; k++) begin
      @(negedge cl_clk);
      cl_lval = 1'b1;
      cl_data = pattern ? {8{10'(k)}} : rand80();
      line_beats[k] = cl_data;
      fpga_msg_overflow = (k == ovf_beat);
    end
    @(negedge cl_clk);
    fpga_msg_overflow = 1'b0;
    cl_data = rand80();
    if (cut) begin
      cl_fval = 1'b0;
      @(negedge cl_clk);
    end
    cl_lval = 1'b0;
  endtask

  task automatic do_line(input int n, input int gap, input bit pattern);
    drive_line(n, -1, pattern, 1'b0);
    mdl_line(mdl_frame, mdl_lnum, n, -1);
    mdl_lnum++;
    repeat (gap - 1) @(negedge cl_clk);
  endtask

  task automatic frame_start();
    @(negedge cl_clk);
    cl_fval = 1'b1;
    mdl_frame++;
    mdl_lnum = 0;
    repeat (2) @(negedge cl_clk);
  endtask

  task automatic frame_end();
    @(negedge cl_clk);
    cl_fval = 1'b0;
    repeat (6) @(negedge cl_clk);
  endtask

  initial begin
    logic [127:0] h1;
    int nl, len;
    reset = 1'b1; capture_en = 1'b1; cl_fval = 1'b0; cl_lval = 1'b0;
    fpga_msg_overflow = 1'b0; cl_data = '0; mdl_frame = 0; mdl_lnum = 0;
    tbl[0] = '{1, 2};   tbl[1] = '{2, 3};   tbl[2] = '{5, 5};
    tbl[3] = '{8, 6};   tbl[4] = '{13, 10}; tbl[5] = '{16, 11};

    repeat (3) @(negedge cl_clk);
    check("reset fpga_msg", fpga_msg, 128'h0);
    check("reset valid", 128'(fpga_msg_valid), 128'h0);
    check("reset frame_num", 128'(frame_num), 128'h0);
    check("reset line_num", 128'(line_num), 128'h0);
    check("reset dropped", 128'(dropped_frames), 128'h0);
    check("reset sync_err", 128'(sync_err), 128'h0);
    reset = 1'b0;
    repeat (4) @(negedge cl_clk);

    // one 8-beat line with a counting pattern
    frame_start();
    drive_line(8, -1, 1'b1, 1'b0);
    mdl_line(mdl_frame, 0, 8, -1);
    mdl_lnum++;
    frame_end();
    h1 = {16'hC1F0, 32'h00001000, 80'h0};
    check("t1 words", 128'(got_q.size()), 128'd6);
    if (got_q.size() >= 2) begin
      check("t1 header", got_q[0], h1);
      check("t1 word0", got_q[1], {line_beats[1][47:0], line_beats[0]});
    end
    compare_stream("t1");

    // 3-beat line ends in a 7-unit flush word
    frame_start();
    do_line(3, 2, 1'b0);
    frame_end();
    check("t2 words", 128'(got_q.size()), 128'd3);
    if (got_q.size() >= 3) check("t2 flush top", 128'(got_q[2][127:112]), 128'h0);
    compare_stream("t2");

    // 3 frames x 4 lines
    for (int f = 0; f < 3; f++) begin
      frame_start();
      for (int l = 0; l < 4; l++) do_line($urandom_range(1, 12), 2, 1'b0);
      frame_end();
      check("t3 frame_num", 128'(frame_num), 128'(mdl_frame));
      check("t3 line_num", 128'(line_num), 128'd4);
      compare_stream("t3");
    end

    // FVAL falls while LVAL is still high
    frame_start();
    drive_line(7, -1, 1'b0, 1'b1);
    mdl_line(mdl_frame, 0, 7, -1);
    frame_end();
    check("fcut line_num", 128'(line_num), 128'd1);
    compare_stream("fcut");

    // one-cycle LVAL gap: residual dropped, next header still sent
    check("t5 sync_err before", 128'(sync_err), 128'h0);
    frame_start();
    drive_line(3, -1, 1'b0, 1'b0);
    mdl_line(mdl_frame, 0, 3, 1);
    mdl_lnum = 1;
    do_line(8, 2, 1'b0);
    frame_end();
    check("t5 sync_err set", 128'(sync_err), 128'h1);
    compare_stream("t5");
    frame_start();
    do_line(4, 3, 1'b0);
    frame_end();
    check("t5 sync_err sticky", 128'(sync_err), 128'h1);
    compare_stream("t5b");

    // overflow mid line 2: everything after beat 5 of that line is dropped
    check("t4 dropped before", 128'(dropped_frames), 128'h0);
    frame_start();
    do_line(6, 2, 1'b0);
    do_line(6, 2, 1'b0);
    drive_line(10, 5, 1'b0, 1'b0);
    mdl_line(mdl_frame, 2, 10, (5 * 80) / 128);
    repeat (2) @(negedge cl_clk);
    drive_line(4, -1, 1'b0, 1'b0);
    frame_end();
    check("t4 dropped", 128'(dropped_frames), 128'h1);
    compare_stream("t4");
    frame_start();
    do_line(9, 2, 1'b0);
    do_line(2, 2, 1'b0);
    frame_end();
    check("t4 dropped hold", 128'(dropped_frames), 128'h1);
    compare_stream("t4b");

    // table of single-line lengths
    for (int i = 0; i < 6; i++) begin
      frame_start();
      do_line(tbl[i].nbeats, 2, 1'b0);
      frame_end();
      check($sformatf("tbl%0d words", i), 128'(got_q.size()), 128'(tbl[i].exp_words));
      compare_stream($sformatf("tbl%0d", i));
    end

    // random frames
    for (int f = 0; f < 8; f++) begin
      nl = $urandom_range(1, 4);
      frame_start();
      for (int l = 0; l < nl; l++) begin
        len = $urandom_range(1, 24);
        do_line(len, $urandom_range(2, 4), 1'b0);
      end
      frame_end();
      check("rnd frame_num", 128'(frame_num), 128'(mdl_frame));
      check("rnd line_num", 128'(line_num), 128'(nl));
      compare_stream($sformatf("rnd%0d", f));
    end

    // reset mid-line with one beat (5 units) in the accumulator
    frame_start();
    @(negedge cl_clk);
    cl_lval = 1'b1; cl_data = rand80();
    @(negedge cl_clk);
    cl_data = rand80();
    @(negedge cl_clk);
    cl_data = rand80();
    #2 reset = 1'b1;
    #1;
    check("rst fpga_msg", fpga_msg, 128'h0);
    check("rst valid", 128'(fpga_msg_valid), 128'h0);
    check("rst frame_num", 128'(frame_num), 128'h0);
    check("rst line_num", 128'(line_num), 128'h0);
    check("rst dropped", 128'(dropped_frames), 128'h0);
    check("rst sync_err", 128'(sync_err), 128'h0);
    cl_fval = 1'b0; cl_lval = 1'b0;
    got_q.delete();
    exp_q.delete();
    mdl_frame = 0;
    @(negedge cl_clk);
    reset = 1'b0;
    repeat (4) @(negedge cl_clk);
    frame_start();
    do_line(3, 2, 1'b0);
    frame_end();
    check("post-rst frame_num", 128'(frame_num), 128'd1);
    compare_stream("post-rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cl_line_packer.md
Name: cl_line_packer

Overview:
- Sits directly downstream of the Camera Link receiver pins and upstream of the 128-bit FPGA-to-PC message FIFO.
- Qualifies the 80-bit CL pixel beats with FVAL/LVAL and gearboxes them 80→128 bits: every 8 input beats become 5 output words.
- Prepends one header word per line carrying frame and line numbers.
- On FIFO overflow, drops the remainder of the current frame and counts the loss.

Parameters:
- FRAME_NUM_SIZE, 20: frame counter width.
- LINE_NUM_SIZE, 12: line counter width. FRAME_NUM_SIZE + LINE_NUM_SIZE must be ≤ 32.
- HDR_MARKER, 16'hC1F0: tag placed in header bits [127:112].
- DROP_CNT_SIZE, 8: width of the dropped-frame counter.

Ports:
- cl_clk, in, 1: CL pixel clock. The only clock in the block.
- reset, in, 1: asynchronous, active-high.
- capture_en, in, 1: capture armed (level, already synchronous to cl_clk).
- cl_fval, in, 1: frame valid.
- cl_lval, in, 1: line valid.
- cl_data, in, 80: 8 taps × 10 bits; beat is valid when cl_fval & cl_lval.
- fpga_msg_overflow, in, 1: downstream FIFO full/overflowed.
- fpga_msg, out, 128: packed output word.
- fpga_msg_valid, out, 1: single-cycle write strobe for fpga_msg.
- frame_num, out, FRAME_NUM_SIZE: current frame number.
- line_num, out, LINE_NUM_SIZE: current line number.
- dropped_frames, out, DROP_CNT_SIZE: frames truncated by overflow; saturates.
- sync_err, out, 1: sticky; LVAL gap too short.

Behaviour:
- Reset values: all outputs 0; accumulator empty; state IDLE.
- All inputs are registered once before use. The latency figures below are measured from the registered inputs.
- Edges: FVAL/LVAL rise and fall are detected against the previous registered sample.

States:
- IDLE: output nothing.
- WAIT_FRAME → ACTIVE: on FVAL rise while capture_en=1.
- ACTIVE → DROP: when fpga_msg_overflow=1.
- DROP → WAIT_FRAME: on FVAL fall.
- ACTIVE → WAIT_FRAME: on FVAL fall.
- Any state → IDLE: capture_en=0. If this happens mid-line, the residual is discarded with no flush.
- IDLE → WAIT_FRAME: capture_en=1.

Counters:
- FVAL rise accepted into ACTIVE: frame_num += 1 (wraps) and line_num ← 0.
- LVAL fall in ACTIVE: line_num += 1 (wraps).

Header:
- Cycle of the first beat of a line (LVAL rise in ACTIVE): emit header word.
- Header layout: [127:112]=HDR_MARKER, [111:80]={zero pad, frame_num, line_num} with line_num in the LSBs, [79:0]=0.
- The gearbox produces no word on that cycle, so there is no slot conflict.

Gearbox:
- Accumulator is 208 bits; fill is tracked in 16-bit units (0..12).
- Each valid beat is written at bit offset fill×16 and fill += 5.
- If the fill before the write is ≥ 3 units (i.e. ≥ 8 units after the add), emit acc[127:0] that same registered cycle, shift right by 128, and fill −= 8.
- The first beat of a line lands at output bits [79:0].
- Output sequence per 8 beats: 0,1,0,1,1,0,1,1 words. fill returns to 0 after each 8-beat group.

Line end:
- On the cycle after LVAL falls, if fill > 0, emit acc[127:0] with unused bits zeroed, then fill ← 0.
- Line lengths are arbitrary; a partial group produces one padded word.

Overflow handling:
- fpga_msg_overflow=1 in ACTIVE: suppress all further writes this frame, including the same-cycle word.
- dropped_frames += 1 once per frame, saturating.
- Accumulator is cleared.

Sync error:
- LVAL low for fewer than 2 cycles between lines: set sync_err (sticky until reset), discard residual, and still emit the next header.

Other boundaries:
- LVAL high outside FVAL: ignored.
- FVAL falling while LVAL is high: treated as LVAL fall (flush), then frame end.
- fpga_msg_valid is never high on two consecutive header cycles.

Decomposition:
- Shared package cl_pkg: FRAME_NUM_SIZE, LINE_NUM_SIZE, HDR_MARKER, header bit-field offsets, state encoding (IDLE / WAIT_FRAME / ACTIVE / DROP), and the existing log2 function.
- One natural sub-module, cl_gearbox_80to128: accumulator, fill count, flush and clear. The parent holds the FSM, counters and header mux.

Test Plan:
1. One line of 8 beats (beat k = {8{10'(k)}}), capture_en=1 → header 0xC1F0 | frame 1 | line 0, then exactly 5 data words. Word0[79:0] = beat0; concatenating the words reproduces the 640 input bits; fill = 0 afterwards.
2. Line of 3 beats → header + 1 full word + 1 flush word whose bits [111:112−16·?] are defined by fill 7 units: bits [111:0] hold data, [127:112]=0.
3. 3 frames × 4 lines → frame_num 1,2,3; line_num in headers 0..3 per frame; line_num reads 4 at the end of each frame.
4. fpga_msg_overflow pulsed mid-line 2 of frame 1 → no writes until the next FVAL rise, then dropped_frames=1. Frame 2 is complete and correct.
5. LVAL low for only 1 cycle between lines → sync_err=1 and stays 1; the next line's header is still emitted.
6. reset asserted mid-line with fill=5 → all outputs 0 immediately; after release, the next frame starts at frame_num 1 with no stale residual data.
